// File: rtl/l2_arbiter.sv
// l2_arbiter: two-port (I-side / D-side) arbiter in front of a single L2 cache port.
// Optional build macro: L2_ARB_FIXED_PRI_EN -- when defined, D always wins contention
// and the priority bit is held at 1; when undefined, priority alternates round-robin.
//
// Handshake: a requester holds its read/write level until it sees its resp pulse.
// The arbiter latches the winning request when it leaves IDLE, then holds the L2
// strobe from those latched values until l2_resp. The resp pulse is l2_resp passed
// through combinationally to the granted side for that single cycle, and the next
// edge always returns to IDLE.
module l2_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  i_address,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [15:0]  d_address,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [15:0]  l2_address,
  output logic         l2_read,
  output logic         l2_write,
  output logic [255:0] l2_wdata,
  input  logic [255:0] l2_rdata,
  input  logic         l2_resp,
  output logic [1:0]   dbg_state,
  output logic         dbg_pri
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           pri;
  logic [15:0]    hold_addr;
  logic [255:0]   hold_wdata;
  logic           hold_write;
  logic           i_req;
  logic           d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Read data is shared; each side qualifies it with its own resp.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  assign l2_address = hold_addr;
  assign l2_wdata   = hold_wdata;

  assign dbg_state = state_q;
  assign dbg_pri   = pri;

  // State register; reset abandons any in-flight grant without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the winning request on the IDLE-to-grant edge; held values drive L2 afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_addr  <= 16'h0000;
      hold_wdata <= '0;
      hold_write <= 1'b0;
    end else if (state_q == IDLE && state_d == GRANT_I) begin
      hold_addr  <= i_address;
      hold_write <= 1'b0;
    end else if (state_q == IDLE && state_d == GRANT_D) begin
      hold_addr  <= d_address;
      hold_wdata <= d_wdata;
      // A simultaneous read+write from D is treated as a write.
      hold_write <= d_write;
    end
  end

`ifdef L2_ARB_FIXED_PRI_EN
  // Fixed priority: D always wins contention.
  assign pri = 1'b1;
`else
  // Round-robin: after a completed grant, the other side gets priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri <= 1'b0;
    end else if (l2_resp) begin
      if (state_q == GRANT_I)      pri <= 1'b1;
      else if (state_q == GRANT_D) pri <= 1'b0;
    end
  end
`endif

  // Next-state decode and L2 / response strobes.
  always_comb begin
    state_d  = state_q;
    l2_read  = 1'b0;
    l2_write = 1'b0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state_q)
      IDLE: begin
        // l2_resp is deliberately ignored here.
        if (i_req && (!d_req || !pri)) state_d = GRANT_I;
        else if (d_req)                state_d = GRANT_D;
      end
      GRANT_I: begin
        l2_read  = ~hold_write;
        l2_write = hold_write;
        if (l2_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        l2_read  = ~hold_write;
        l2_write = hold_write;
        if (l2_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed testbench for l2_arbiter: I read, D write, contention/priority,
// requester drop, reset mid-grant, stray l2_resp in IDLE, restart after reset.
module tb_l2_arbiter;

`ifdef L2_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GI   = 2'd1;
  localparam logic [1:0] S_GD   = 2'd2;

  logic         clk;
  logic         rst = 1'b0;
  logic [15:0]  i_address;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [15:0]  d_address;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [15:0]  l2_address;
  logic         l2_read;
  logic         l2_write;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;
  logic [1:0]   dbg_state;
  logic         dbg_pri;

  int checks = 0;
  int errors = 0;

  l2_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_address  (i_address),
    .i_read     (i_read),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_address  (d_address),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_address (l2_address),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp),
    .dbg_state  (dbg_state),
    .dbg_pri    (dbg_pri)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]   s_exp;
  logic [255:0] rd_val;
  logic [255:0] wd_a5;

  initial begin
    i_address = '0; i_read = 0;
    d_address = '0; d_read = 0; d_write = 0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 0;
    wd_a5 = {32{8'hA5}};

    // ---- Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_state",    256'(dbg_state), 256'(S_IDLE));
    chk("rst_pri",      256'(dbg_pri),   256'(FIXED));
    chk("rst_l2_read",  256'(l2_read),   256'(0));
    chk("rst_l2_write", 256'(l2_write),  256'(0));
    chk("rst_i_resp",   256'(i_resp),    256'(0));
    chk("rst_d_resp",   256'(d_resp),    256'(0));
    chk("rst_l2_addr",  256'(l2_address), 256'(0));
    chk("rst_l2_wdata", l2_wdata,        256'(0));
    tick(); tick();
    rst = 1'b0;

    // ---- I-only read
    i_read = 1; i_address = 16'h1240;
    #1;
    chk("i_lat_idle_state", 256'(dbg_state), 256'(S_IDLE));
    chk("i_lat_idle_read",  256'(l2_read),   256'(0));
    tick();
    chk("i_state",    256'(dbg_state),  256'(S_GI));
    chk("i_l2_read",  256'(l2_read),    256'(1));
    chk("i_l2_write", 256'(l2_write),   256'(0));
    chk("i_l2_addr",  256'(l2_address), 256'(16'h1240));
    // Requester drops; strobe and latched address must hold.
    i_read = 0; i_address = 16'hBEEF;
    tick();
    chk("i_drop_read", 256'(l2_read),    256'(1));
    chk("i_drop_addr", 256'(l2_address), 256'(16'h1240));
    chk("i_wait_resp", 256'(i_resp),     256'(0));
    rd_val = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    l2_rdata = rd_val;
    l2_resp = 1;
    #1;
    chk("i_resp",    256'(i_resp), 256'(1));
    chk("i_d_resp",  256'(d_resp), 256'(0));
    chk("i_rdata",   i_rdata, rd_val);
    chk("d_rdata",   d_rdata, rd_val);
    tick();
    l2_resp = 0;
    #1;
    chk("i_done_state", 256'(dbg_state), 256'(S_IDLE));
    chk("i_done_read",  256'(l2_read),   256'(0));
    chk("i_done_resp",  256'(i_resp),    256'(0));
    chk("i_done_pri",   256'(dbg_pri),   256'(1));

    // ---- D write
    d_write = 1; d_address = 16'h3FE0; d_wdata = wd_a5;
    tick();
    chk("d_state",    256'(dbg_state),  256'(S_GD));
    chk("d_l2_write", 256'(l2_write),   256'(1));
    chk("d_l2_read",  256'(l2_read),    256'(0));
    chk("d_l2_addr",  256'(l2_address), 256'(16'h3FE0));
    chk("d_l2_wdata", l2_wdata,         wd_a5);
    d_write = 0; d_wdata = '0;
    l2_resp = 1;
    #1;
    chk("d_resp",   256'(d_resp), 256'(1));
    chk("d_i_resp", 256'(i_resp), 256'(0));
    tick();
    l2_resp = 0;
    #1;
    chk("d_done_state", 256'(dbg_state), 256'(S_IDLE));
    chk("d_done_write", 256'(l2_write),  256'(0));
    chk("d_done_pri",   256'(dbg_pri),   256'(FIXED));

    // ---- Contention: both sides held for three grants; D issues read+write.
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_write = 1; d_address = 16'h0200; d_wdata = 256'h5A5A_0001;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) s_exp = S_GD;
      else        s_exp = FIXED ? S_GD : S_GI;
      tick();
      chk("con_state",    256'(dbg_state),  256'(s_exp));
      chk("con_l2_read",  256'(l2_read),    256'(s_exp == S_GI));
      chk("con_l2_write", 256'(l2_write),   256'(s_exp == S_GD));
      chk("con_l2_addr",  256'(l2_address), 256'(s_exp == S_GI ? 16'h0100 : 16'h0200));
      l2_resp = 1;
      #1;
      chk("con_i_resp", 256'(i_resp), 256'(s_exp == S_GI));
      chk("con_d_resp", 256'(d_resp), 256'(s_exp == S_GD));
      tick();
      l2_resp = 0;
      #1;
      chk("con_gap_state", 256'(dbg_state), 256'(S_IDLE));
      chk("con_gap_read",  256'(l2_read),   256'(0));
      chk("con_gap_write", 256'(l2_write),  256'(0));
      chk("con_pri",       256'(dbg_pri),   256'(FIXED ? 1'b1 : (s_exp == S_GI)));
    end
    i_read = 0; d_read = 0; d_write = 0;
    tick();
    chk("con_quiet_state", 256'(dbg_state), 256'(S_IDLE));

    // ---- Reset mid GRANT_D
    d_write = 1; d_address = 16'h5550; d_wdata = 256'h1234;
    tick();
    chk("rd_state",    256'(dbg_state), 256'(S_GD));
    chk("rd_l2_write", 256'(l2_write),  256'(1));
    #1 rst = 1'b1;
    #1;
    chk("rd_write_fall", 256'(l2_write),   256'(0));
    chk("rd_state_idle", 256'(dbg_state),  256'(S_IDLE));
    chk("rd_pri",        256'(dbg_pri),    256'(FIXED));
    chk("rd_addr_clr",   256'(l2_address), 256'(0));
    chk("rd_wdata_clr",  l2_wdata,         256'(0));
    l2_resp = 1;
    #1;
    chk("rd_no_d_resp", 256'(d_resp), 256'(0));
    d_write = 0; l2_resp = 0;
    tick();
    rst = 1'b0;

    // ---- Stray l2_resp in IDLE
    l2_resp = 1;
    #1;
    chk("stray_i_resp", 256'(i_resp), 256'(0));
    chk("stray_d_resp", 256'(d_resp), 256'(0));
    tick();
    chk("stray_state",  256'(dbg_state), 256'(S_IDLE));
    chk("stray_read",   256'(l2_read),   256'(0));
    l2_resp = 0;

    // ---- Arbitration restarts after reset
    i_read = 1; i_address = 16'h7777;
    tick();
    chk("rs_state", 256'(dbg_state),  256'(S_GI));
    chk("rs_addr",  256'(l2_address), 256'(16'h7777));
    i_read = 0;
    l2_resp = 1;
    #1;
    chk("rs_i_resp", 256'(i_resp), 256'(1));
    tick();
    l2_resp = 0;
    #1;
    chk("rs_done_state", 256'(dbg_state), 256'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port i_address, input, 16 bits (lc3b_word): I-side line address.
REQ-004 SHALL have port i_read, input, 1 bit: I-side read request.
REQ-005 SHALL have port i_rdata, output, 256 bits (lc3b_c_block): I-side read line.
REQ-006 SHALL have port i_resp, output, 1 bit: I-side completion.
REQ-007 SHALL have port d_address, input, 16 bits: D-side line address.
REQ-008 SHALL have ports d_read and d_write, input, 1 bit each: D-side read and write requests.
REQ-009 SHALL have port d_wdata, input, 256 bits: D-side write line.
REQ-010 SHALL have ports d_rdata (256 bits) and d_resp (1 bit), outputs: D-side read line and completion.
REQ-011 SHALL have ports l2_address (16 bits), l2_read (1 bit), l2_write (1 bit) and l2_wdata (256 bits), outputs: L2 cache request.
REQ-012 SHALL have ports l2_rdata (256 bits) and l2_resp (1 bit), inputs: L2 cache return.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT_I and GRANT_D.
REQ-014 SHALL, in IDLE, assert no l2_read, l2_write, i_resp or d_resp.
REQ-015 SHALL, in IDLE, go to GRANT_I when only i_read is high, and to GRANT_D when only (d_read|d_write) is high.
REQ-016 SHALL, in IDLE with both sides requesting, grant the side indicated by the 1-bit priority register pri (0=I, 1=D).
REQ-017 SHALL, on the IDLE-to-grant edge, latch the granted side's address, read/write type and (for D) d_wdata into holding registers.
REQ-018 SHALL, in GRANT_x, drive l2_address, l2_wdata, l2_read and l2_write from the holding registers only; later requester changes are ignored.
REQ-019 SHALL give a latency of exactly 1 cycle from a request sampled in IDLE to l2_read/l2_write asserted.
REQ-020 SHALL hold the L2 strobe until l2_resp, even if the requester deasserts.
REQ-021 SHALL, in GRANT_x with l2_resp=1, assert x_resp combinationally in that same cycle, for exactly that cycle.
REQ-022 SHALL, in GRANT_x with l2_resp=1, return to IDLE on the next edge.
REQ-023 SHALL, in GRANT_x with l2_resp=1, set pri to the opposite side (pri<=1 after I, pri<=0 after D).
REQ-024 SHALL stay in GRANT_x, outputs unchanged, while l2_resp=0; there is no timeout.
REQ-025 SHALL drive l2_rdata onto both i_rdata and d_rdata unconditionally; it is valid only with the matching resp.
REQ-026 SHALL forward d_read=d_write=1 as a write (l2_write=1, l2_read=0).
REQ-027 SHALL, as a result of the mandatory IDLE cycle after each completion, keep back-to-back grants at least 1 cycle apart.
REQ-028 SHALL ignore l2_resp while in IDLE.

Reset
REQ-029 SHALL, on rst asserted, immediately and asynchronously force state=IDLE and pri=0.
REQ-030 SHALL, on rst asserted, clear the holding registers to 0.
REQ-031 SHALL, on rst asserted, force l2_read, l2_write, i_resp and d_resp to 0.
REQ-032 SHALL abandon any transaction cut by reset mid-GRANT with no response issued.
REQ-033 SHALL restart arbitration on the first rising edge after rst deasserts.

Configuration
REQ-034 SHALL support the macro L2_ARB_FIXED_PRI_EN.
REQ-035 SHALL, when L2_ARB_FIXED_PRI_EN is defined, always grant D over I on contention, holding pri constant at 1 (REQ-023 disabled).
REQ-036 SHALL, when L2_ARB_FIXED_PRI_EN is undefined, alternate priority per REQ-016 and REQ-023 (round-robin).

Verification
REQ-037 SHALL cover I-only read: i_read=1, i_address=0x1240 -> next cycle l2_read=1, l2_address=0x1240; l2_resp pulse -> i_resp=1 same cycle, d_resp=0.
REQ-038 SHALL cover D write: d_write=1, d_address=0x3FE0, d_wdata=all-0xA5 -> l2_write=1 with that data; d_resp pulses with l2_resp; then IDLE.
REQ-039 SHALL cover contention after reset (pri=0): I granted first, then D after the one-cycle IDLE gap; a second contention grants I (round-robin), or D when L2_ARB_FIXED_PRI_EN is defined.
REQ-040 SHALL cover requester drop: i_read drops during GRANT_I -> l2_read stays 1 with the latched address until l2_resp.
REQ-041 SHALL cover reset mid-GRANT_D: l2_write falls within the rst cycle, no d_resp, state IDLE, pri=0.
REQ-042 SHALL cover a stray l2_resp in IDLE: no i_resp, no d_resp, no state change.
